// File: rtl/lift_scheduler.sv
// lift_scheduler: directional-sweep lift controller with door timer and display scan strobe
module lift_scheduler #(
    parameter int FLOORS   = 12,
    parameter int MOVE_CYC = 50_000_000,
    parameter int DOOR_CYC = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [FLOORS-1:0] call_req,
    output logic [3:0]        floor,
    output logic              scan,
    output logic [FLOORS-1:0] pending,
    output logic              moving,
    output logic              dir_up,
    output logic              door_open
);
    localparam int TMAX = MOVE_CYC > DOOR_CYC ? MOVE_CYC : DOOR_CYC;
    localparam int TW = $clog2(TMAX + 1);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam logic [TW-1:0] MOVE_LD = TW'(MOVE_CYC - 1);
    localparam logic [TW-1:0] DOOR_LD = TW'(DOOR_CYC - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

    state_t            state;
    logic [TW-1:0]     timer;
    logic [SW-1:0]     scan_cnt;
    logic [3:0]        floor_nx;
    logic [FLOORS-1:0] cur_bit;
    logic [FLOORS-1:0] nx_bit;
    logic [FLOORS-1:0] clear_mask;
    logic              above;
    logic              below;
    logic              arrive;
    logic              into_door;
    logic              go_up;

    // Call geometry relative to the car, next floor, and whether this edge opens the door
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            above = above | (pending[i] & (4'(i + 1) > floor));
            below = below | (pending[i] & (4'(i + 1) < floor));
        end
        go_up = above && (dir_up || !below);
        arrive = (state == MOVE_UP || state == MOVE_DOWN) && timer == '0;
        floor_nx = !arrive ? floor : (state == MOVE_UP ? floor + 4'd1 : floor - 4'd1);
        cur_bit = FLOORS'(1) << (floor - 4'd1);
        nx_bit = FLOORS'(1) << (floor_nx - 4'd1);
        into_door = (state == IDLE && |(pending & cur_bit)) || (arrive && |(pending & nx_bit));
        clear_mask = (state == DOOR || into_door) ? nx_bit : '0;
    end

    // Car FSM: request latch, position, travel/door timer and registered status
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            floor     <= 4'd1;
            pending   <= '0;
            moving    <= 1'b0;
            door_open <= 1'b0;
            dir_up    <= 1'b1;
            timer     <= '0;
        end else begin
            pending <= (pending | call_req) & ~clear_mask;
            floor   <= floor_nx;
            if (into_door) begin
                state     <= DOOR;
                timer     <= DOOR_LD;
                moving    <= 1'b0;
                door_open <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (above || below) begin
                            state  <= go_up ? MOVE_UP : MOVE_DOWN;
                            dir_up <= go_up;
                            timer  <= MOVE_LD;
                            moving <= 1'b1;
                        end
                    end
                    MOVE_UP, MOVE_DOWN: timer <= arrive ? MOVE_LD : timer - 1'b1;
                    DOOR: begin
                        if (|(call_req & cur_bit)) begin
                            timer <= DOOR_LD;
                        end else if (timer == '0) begin
                            state     <= IDLE;
                            door_open <= 1'b0;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Free-running digit-scan divider, toggles on every wrap
    always_ff @(posedge clk) begin
        if (clr) begin
            scan_cnt <= '0;
            scan     <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan     <= ~scan;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_lift_scheduler.sv
// tb_lift_scheduler: directed checks of sweep order, door timing, resets and scan strobe
module tb_lift_scheduler;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] call_req = '0;
    logic [3:0] floor;
    logic       scan;
    logic [7:0] pending;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    int         n_chk = 0;
    int         n_fail = 0;
    int         exp_scan [5] = '{0, 0, 1, 1, 0};

    lift_scheduler #(.FLOORS(8), .MOVE_CYC(4), .DOOR_CYC(3), .SCAN_DIV(2)) dut (
        .clk(clk), .clr(clr), .call_req(call_req), .floor(floor), .scan(scan),
        .pending(pending), .moving(moving), .dir_up(dir_up), .door_open(door_open)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] m);
        call_req = m;
        step(1);
        call_req = '0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step(2);
        clr = 1'b0;
    endtask

    initial begin
        // reset values and scan waveform
        step(2);
        clr = 1'b0;
        chk("rst_floor", floor, 1);
        chk("rst_pending", pending, 0);
        chk("rst_moving", moving, 0);
        chk("rst_door", door_open, 0);
        chk("rst_dir", dir_up, 1);
        for (int i = 0; i < 5; i++) begin
            chk("scan_seq", scan, exp_scan[i]);
            step(1);
        end
        // single call to floor 4
        press(8'h08);
        chk("s2_pend", pending, 8'h08);
        chk("s2_mov0", moving, 0);
        step(1);
        chk("s2_mov1", moving, 1);
        chk("s2_dir", dir_up, 1);
        step(3);
        chk("s2_f1", floor, 1);
        step(1);
        chk("s2_f2", floor, 2);
        step(4);
        chk("s2_f3", floor, 3);
        step(4);
        chk("s2_f4", floor, 4);
        chk("s2_door", door_open, 1);
        chk("s2_movoff", moving, 0);
        chk("s2_pclr", pending, 0);
        step(2);
        chk("s2_door3", door_open, 1);
        step(1);
        chk("s2_doorend", door_open, 0);
        chk("s2_idle", moving, 0);
        chk("s2_fstay", floor, 4);
        // sweep order 3 then 6, then back down to 2
        do_reset();
        press(8'h24);
        step(9);
        chk("s3_f3", floor, 3);
        chk("s3_door3", door_open, 1);
        chk("s3_pend", pending, 8'h20);
        step(3);
        chk("s3_idle", door_open, 0);
        chk("s3_idlemov", moving, 0);
        step(1);
        chk("s3_go", moving, 1);
        step(12);
        chk("s3_f6", floor, 6);
        chk("s3_door6", door_open, 1);
        chk("s3_pend0", pending, 0);
        step(3);
        chk("s3_idle6", door_open, 0);
        press(8'h02);
        step(1);
        chk("s3_dirdn", dir_up, 0);
        chk("s3_movdn", moving, 1);
        step(16);
        chk("s3_f2", floor, 2);
        chk("s3_door2", door_open, 1);
        // same-floor calls and door extension
        do_reset();
        press(8'h01);
        chk("s4_pend", pending, 1);
        chk("s4_door0", door_open, 0);
        step(1);
        chk("s4_door", door_open, 1);
        chk("s4_pclr", pending, 0);
        chk("s4_nomove", moving, 0);
        step(1);
        press(8'h01);
        chk("s4_absorb", pending, 0);
        step(2);
        chk("s4_ext", door_open, 1);
        chk("s4_absorb2", pending, 0);
        step(1);
        chk("s4_close", door_open, 0);
        chk("s4_floor", floor, 1);
        // departed-floor call
        do_reset();
        press(8'h12);
        step(9);
        chk("s5_mov", moving, 1);
        chk("s5_f2", floor, 2);
        press(8'h02);
        chk("s5_latch", pending, 8'h12);
        step(11);
        chk("s5_f5", floor, 5);
        chk("s5_door5", door_open, 1);
        chk("s5_pend", pending, 8'h02);
        step(4);
        chk("s5_dirdn", dir_up, 0);
        chk("s5_movdn", moving, 1);
        step(12);
        chk("s5_back2", floor, 2);
        chk("s5_door2", door_open, 1);
        chk("s5_pend0", pending, 0);
        // reset mid-move
        do_reset();
        press(8'h50);
        step(10);
        chk("s6_f3", floor, 3);
        chk("s6_mov", moving, 1);
        clr = 1'b1;
        call_req = 8'h08;
        step(1);
        clr = 1'b0;
        call_req = '0;
        chk("s6_floor", floor, 1);
        chk("s6_pend", pending, 0);
        chk("s6_mov0", moving, 0);
        chk("s6_door", door_open, 0);
        chk("s6_dir", dir_up, 1);
        chk("s6_scan", scan, 0);
        step(10);
        chk("s6_stay", floor, 1);
        chk("s6_still", moving, 0);
        chk("s6_nopend", pending, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lift_scheduler.md
# lift_scheduler

Lift car controller for the floor-display path: latches floor-call requests, runs the car up and down with a directional sweep, and times the door. It produces the 4-bit current-floor value that drives the seven-segment floor display. It also produces the slow digit-scan strobe that the display multiplexer uses as its digit select. The block sits between the call buttons and the display, and owns the only copy of car position.

## Interface

Parameters:
- FLOORS, 12, number of floors, numbered 1..FLOORS; legal range 2..15.
- MOVE_CYC, 50_000_000, clock cycles to travel one floor; must be ≥1.
- DOOR_CYC, 100_000_000, clock cycles the door stays open; must be ≥1.
- SCAN_DIV, 100_000, clock cycles between toggles of `scan`; must be ≥1.

Ports:
- clk  in  1  system clock; single clock domain.
- clr  in  1  reset; **synchronous, active-high**.
- call_req  in  FLOORS  call pulses; bit i-1 is a request for floor i; multi-cycle or multi-bit pulses are legal.
- floor  out  4  current car floor, 1..FLOORS, binary; drives the display value input.
- scan  out  1  digit-scan strobe, square wave; drives the display digit select.
- pending  out  FLOORS  latched, not-yet-served calls.
- moving  out  1  car is travelling between floors.
- dir_up  out  1  current or last sweep direction; 1 = up.
- door_open  out  1  door is open at `floor`.

## Operation

- **State machine:** IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- **Request register:** `pending <= (pending | call_req) & ~clear_mask`.
  - `clear_mask` is the current-floor bit, asserted only on cycles where the state is, or is being entered as, DOOR.
  - A call arriving on a clear cycle for the same floor is absorbed, not latched.
- **IDLE**, evaluated on `pending` each cycle:
  - If the current-floor bit is set → DOOR.
  - Else if calls exist both above and below, continue in direction `dir_up`.
  - Else if calls exist above only → MOVE_UP, `dir_up`=1.
  - Else if calls exist below only → MOVE_DOWN, `dir_up`=0.
  - Else stay in IDLE.
- **MOVE_UP / MOVE_DOWN:**
  - On entry, load the travel timer with MOVE_CYC-1; decrement each cycle.
  - At timer 0, `floor` steps ±1.
  - If the new floor is pending → DOOR.
  - Otherwise reload the timer and continue in the same direction.
  - A sweep always has a call ahead, so the car never passes floor 1 or FLOORS.
- **Calls during travel:** a call for the floor just departed is latched and served on a later sweep. A call for a floor ahead is served in the current sweep.
- **DOOR:**
  - On entry, load the door timer with DOOR_CYC-1 and clear the floor's pending bit.
  - A new call for the current floor while in DOOR reloads the door timer and is not latched.
  - At timer 0 → IDLE.
  - `dir_up` is retained so the next decision continues the sweep.
- **Scan divider:** a free-running counter 0..SCAN_DIV-1; `scan` toggles when the counter wraps. It is independent of the FSM.
- **Width rule:** `floor` is 4 bits, zero-extended; it never leaves 1..FLOORS.

## Timing

- **Reset** (`clr` high at a clock edge): next cycle `floor`=1, IDLE, `pending`=0, `moving`=0, `door_open`=0, `dir_up`=1, `scan`=0, all timers and the scan counter 0.
- **Reset mid-operation:** it overrides every state and discards calls. A `call_req` sampled in the same cycle as `clr` is dropped.
- **Call latency:** `call_req` high at edge N → `pending` bit set after edge N. If the FSM is IDLE, it leaves IDLE at edge N+1.
- **Registered status outputs:**
  - `moving` is high exactly while in MOVE_UP or MOVE_DOWN.
  - `door_open` is high exactly while in DOOR.
- **Travel:** `floor` updates MOVE_CYC cycles after entering MOVE; each further floor takes another MOVE_CYC cycles.
- **Door:** `door_open` lasts exactly DOOR_CYC cycles, absent reloads. It is followed by at least one IDLE cycle before the next move.
- **Call at the current floor while IDLE:** DOOR is entered at edge N+1; the `pending` bit is visible high for exactly one cycle.
- **`scan` period:** 2·SCAN_DIV cycles, 50% duty.

## Test plan

All scenarios use FLOORS=8, MOVE_CYC=4, DOOR_CYC=3, SCAN_DIV=2.

1. **Reset values:** hold `clr` 2 cycles → `floor`=1, `pending`=0, `moving`=0, `door_open`=0, `dir_up`=1. Then `scan` toggles every 2 cycles (0,0,1,1,0…).
2. **Single call:** pulse the call for floor 4 from idle at floor 1 → `moving` rises 1 cycle after `pending[3]`. `floor` reads 2, 3, 4 at 4-cycle intervals. At 4, `door_open` is high 3 cycles and `pending`=0. Then IDLE.
3. **Sweep order:** at floor 1, call floors 6 and 3 together → doors open at 3, then at 6. Then call floor 2 → `dir_up`=0 and the car travels 6→2.
4. **Same-floor calls:**
   - Call for floor 1 while idle at 1 → `door_open` for 3 cycles, no movement.
   - Repeat the call for floor 1 during the door → `door_open` is extended to 3 cycles after the last call. `pending[0]` stays 0.
5. **Departed-floor call:** moving up from floor 2 with `floor`=2, call floor 2 → the car continues to its target, then returns to 2 with `dir_up`=0.
6. **Reset mid-move:** assert `clr` while moving 3→5 → next cycle all reset values. Prior calls are not served.
